// File: rtl/apb_requester_if.sv
// Command/response stream plus APB bus bundle for apb_requester.
// master is the requester's view; slave is the view of whatever drives/serves it.
interface apb_requester_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error;

  logic [ADDR_WIDTH-1:0] apb_PADDR;
  logic                  apb_PSEL;
  logic                  apb_PENABLE;
  logic                  apb_PWRITE;
  logic [31:0]           apb_PWDATA;
  logic                  apb_PREADY;
  logic [31:0]           apb_PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, apb_PREADY, apb_PRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
           apb_PADDR, apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, apb_PREADY, apb_PRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
           apb_PADDR, apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PWDATA
  );
endinterface

// File: rtl/apb_requester.sv
// Single-outstanding APB initiator: command stream in, APB transfer, response stream out.
// Define ENDEAVOUR_APB_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYCLES.
module apb_requester #(
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic          clk,
  input logic          reset,
  apb_requester_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_requester: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
  logic                  pwrite_reg, pwrite_next;
  logic [31:0]           pwdata_reg, pwdata_next;
  logic                  psel_reg, psel_next;
  logic                  penable_reg, penable_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [31:0]           rsp_rdata_reg, rsp_rdata_next;
  logic                  rsp_error_reg, rsp_error_next;

`ifdef ENDEAVOUR_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Abort fires in the ACCESS cycle that would bring the stall count to the limit.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
`endif

  // Gated by reset so the handshake is closed while reset is held.
  assign bus.cmd_ready   = (state_reg == IDLE) && !reset;
  assign bus.apb_PADDR   = paddr_reg;
  assign bus.apb_PWRITE  = pwrite_reg;
  assign bus.apb_PWDATA  = pwdata_reg;
  assign bus.apb_PSEL    = psel_reg;
  assign bus.apb_PENABLE = penable_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_rdata   = rsp_rdata_reg;
  assign bus.rsp_error   = rsp_error_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      paddr_reg     <= '0;
      pwrite_reg    <= 1'b0;
      pwdata_reg    <= '0;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_error_reg <= 1'b0;
`ifdef ENDEAVOUR_APB_TIMEOUT_EN
      tmo_cnt_reg   <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      paddr_reg     <= paddr_next;
      pwrite_reg    <= pwrite_next;
      pwdata_reg    <= pwdata_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_error_reg <= rsp_error_next;
`ifdef ENDEAVOUR_APB_TIMEOUT_EN
      tmo_cnt_reg   <= tmo_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    paddr_next     = paddr_reg;
    pwrite_next    = pwrite_reg;
    pwdata_next    = pwdata_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_error_next = rsp_error_reg;
`ifdef ENDEAVOUR_APB_TIMEOUT_EN
    tmo_cnt_next   = tmo_cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          paddr_next  = bus.cmd_addr;
          pwrite_next = bus.cmd_write;
          pwdata_next = bus.cmd_wdata;
          psel_next   = 1'b1;
          state_next  = SETUP;
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
`ifdef ENDEAVOUR_APB_TIMEOUT_EN
        tmo_cnt_next = '0;
`endif
      end
      ACCESS: begin
        if (bus.apb_PREADY) begin
          rsp_rdata_next = pwrite_reg ? 32'h0 : bus.apb_PRDATA;
          rsp_error_next = 1'b0;
          rsp_valid_next = 1'b1;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          state_next     = RESP;
        end
`ifdef ENDEAVOUR_APB_TIMEOUT_EN
        else if (tmo_cnt_reg == TMO_LAST) begin
          rsp_rdata_next = 32'h0;
          rsp_error_next = 1'b1;
          rsp_valid_next = 1'b1;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          state_next     = RESP;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- Single-outstanding APB initiator that converts a valid/ready command stream into APB transfers and returns each result on a valid/ready response stream.
- Drives the APB completer side of peripherals such as the board controller (LEDs at 0x0, keys at 0x4, CPU frequency at 0x8).
- Used by debug/boot logic to reach peripheral registers without going through the CPU.

Parameters:
- ADDR_WIDTH, 4, width of cmd_addr and apb_PADDR.
- TIMEOUT_CYCLES, 256, ACCESS-phase cycles without PREADY before the transfer is aborted (only with the optional feature).

Ports:
- clk  input  1  sole clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when high together with cmd_valid.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  target register address.
- cmd_wdata  input  32  write data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed when high together with rsp_valid.
- rsp_rdata  output  32  read data; 0 for writes.
- rsp_error  output  1  transfer aborted by timeout.
- apb_PADDR  output  ADDR_WIDTH  APB address.
- apb_PSEL  output  1  APB select.
- apb_PENABLE  output  1  APB enable.
- apb_PWRITE  output  1  APB direction.
- apb_PWDATA  output  32  APB write data.
- apb_PREADY  input  1  completer ready.
- apb_PRDATA  input  32  completer read data.

Behaviour:
- All outputs are registered except cmd_ready, which is decoded from state.
- Reset is asynchronous: state goes to IDLE immediately, every output goes to 0, and the timeout counter clears. This applies even mid-transfer; the in-flight transfer is dropped and no response is produced.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, held for exactly one cycle, then go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. In the cycle PREADY=1:
    - capture PRDATA into rsp_rdata for reads, or 0 for writes;
    - set rsp_error=0 and rsp_valid=1;
    - clear PSEL/PENABLE on the next edge and go to RESP.
  - RESP: rsp_valid held with rsp_rdata/rsp_error stable until rsp_ready=1, then rsp_valid=0 and go to IDLE.
- cmd_ready=0 in SETUP, ACCESS and RESP. Only one transfer is outstanding at a time.
- Minimum cost is 4 cycles per command (IDLE accept, SETUP, ACCESS with immediate PREADY, RESP with immediate rsp_ready). rsp_valid rises 2 cycles after acceptance when PREADY is immediate.
- PADDR/PWRITE/PWDATA stay constant from SETUP through the end of ACCESS and keep their last values until the next acceptance.
- PREADY is ignored outside ACCESS. PREADY=1 in the first ACCESS cycle completes the transfer in that cycle.
- PSEL never drops while PENABLE is high; PENABLE is never high without PSEL.
- rsp_ready asserted while rsp_valid=0 has no effect.
- cmd_valid during a busy state is not accepted; the command remains pending on the input.

Optional Feature:
- Macro: ENDEAVOUR_APB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on SETUP and increments every ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES while PREADY is still 0, the transfer is aborted: PSEL/PENABLE go to 0 next edge, rsp_valid=1, rsp_error=1, rsp_rdata=0, state goes to RESP.
  - PREADY=1 in the same cycle as the limit is reached takes priority and completes normally with rsp_error=0.
- Undefined: no counter; ACCESS waits indefinitely for PREADY; rsp_error is constant 0.

Test Plan:
- Write 0x5 to addr 0x0 with PREADY tied 1 -> one SETUP cycle (PSEL=1, PENABLE=0), one ACCESS cycle, PWDATA=0x5, PWRITE=1; then rsp_valid=1, rsp_rdata=0, rsp_error=0.
- Read addr 0x8 with PRDATA=0x0588_0A00 and PREADY low for 3 ACCESS cycles -> PADDR/PSEL/PENABLE stable for all 4 ACCESS cycles; rsp_rdata=0x0588_0A00.
- Hold rsp_ready=0 for 10 cycles after a read response while cmd_valid=1 -> rsp_valid and rsp_rdata stable, cmd_ready=0; the next command is accepted only in the cycle after rsp_ready is asserted.
- Assert reset during ACCESS of a write -> PSEL, PENABLE, rsp_valid and cmd_ready all 0 before the next clock edge; after release, cmd_ready=1 and no stale response appears.
- With ENDEAVOUR_APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY stuck 0 -> exactly 8 ACCESS cycles, then rsp_error=1, rsp_rdata=0; PREADY=1 on the 8th cycle instead gives rsp_error=0.
- Back-to-back commands with cmd_valid held high and rsp_ready=1 -> a new transfer every 4 cycles, and each response matches its command's order and data.
